pipeline_sequencer: RTL and testbench

Run/step/halt sequencer and hazard controller for the 5-stage MIPS pipeline. It sits between the debug command interface and the pipeline registers. It generates the global pipeline enable, PC and IF/ID write enables, load-use stall bubbles and branch/jump flushes. It detects the HALT instruction in ID, drains the pipeline, and keeps an executed-cycle counter for the debug unit.

---
 rtl/pipeline_sequencer.sv | 119 +++++++++++
 tb/tb_pipeline_sequencer.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_sequencer.sv
// Run/step/halt sequencer and hazard controller for the 5-stage MIPS pipeline.
// Drives pipeline write enables, load-use bubbles, branch flushes and a drain-to-DONE halt.
module pipeline_sequencer #(
  parameter int DRAIN_CYCLES = 4,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  input  logic [1:0]       cmd_code,
  output logic             cmd_ready,
  input  logic             halt_in_id,
  input  logic             id_ex_mem_read,
  input  logic [4:0]       id_ex_rt,
  input  logic [4:0]       if_id_rs,
  input  logic [4:0]       if_id_rt,
  input  logic             branch_taken,
  output logic             pipe_en,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_bubble,
  output logic             pipe_clear,
  output logic [2:0]       state,
  output logic             done,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_STEP  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_PAUSE = 2'b10;
  localparam logic [1:0] CMD_CLEAR = 2'b11;

  localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [DW-1:0]    drain_q, drain_d;
  logic [CNT_W-1:0] count_q;
  logic             pipe_clear_q;
  logic             stall, halt_now, cmd_fire, clear_fire;
  logic             in_drain;

  // Every combinational output is gated by reset so nothing toggles the pipeline while held.
  assign pipe_en   = ~reset & (state_q == S_RUN || state_q == S_STEP || state_q == S_DRAIN);
  assign cmd_ready = ~reset & (state_q == S_IDLE || state_q == S_RUN || state_q == S_DONE);
  assign in_drain  = ~reset & (state_q == S_DRAIN);
  assign done      = ~reset & (state_q == S_DONE);

  assign stall = pipe_en & id_ex_mem_read & (id_ex_rt != 5'd0) &
                 ((id_ex_rt == if_id_rs) | (id_ex_rt == if_id_rt));

  // HALT is only taken once its own operands are valid, and it pre-empts any command.
  assign halt_now   = ~reset & halt_in_id & (state_q == S_RUN || state_q == S_STEP) & ~stall;
  assign cmd_fire   = cmd_valid & cmd_ready & ~halt_now;
  assign clear_fire = cmd_fire & (cmd_code == CMD_CLEAR);

  assign pc_write     = pipe_en & ~stall & ~halt_now & ~in_drain;
  assign if_id_write  = pc_write;
  assign if_id_flush  = pipe_en & branch_taken & ~stall & ~halt_now & ~in_drain;
  assign id_ex_bubble = stall | halt_now | in_drain;

  assign state       = state_q;
  assign pipe_clear  = pipe_clear_q;
  assign cycle_count = count_q;

  always_comb begin
    // NOTE: defaults first so every path assigns state_d/drain_d and no latch is inferred.
    state_d = state_q;
    drain_d = drain_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_fire && cmd_code == CMD_RUN)  state_d = S_RUN;
        if (cmd_fire && cmd_code == CMD_STEP) state_d = S_STEP;
      end
      S_RUN: begin
        if (cmd_fire && (cmd_code == CMD_PAUSE || cmd_code == CMD_CLEAR)) state_d = S_IDLE;
      end
      S_STEP:  state_d = S_IDLE;
      S_DRAIN: begin
        if (drain_q == '0) state_d = S_DONE;
        else               drain_d = drain_q - DW'(1);
      end
      S_DONE: begin
        if (clear_fire) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (halt_now) begin
      state_d = S_DRAIN;
      drain_d = DRAIN_LOAD;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      drain_q      <= '0;
      count_q      <= '0;
      pipe_clear_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      drain_q      <= drain_d;
      pipe_clear_q <= clear_fire;
      if (clear_fire)                  count_q <= '0;
      else if (pipe_en && !(&count_q)) count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Directed bench for pipeline_sequencer: stimulus pushes expected output snapshots,
// a negedge monitor pops and compares them against the live DUT outputs.
module tb_pipeline_sequencer;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic [1:0]       cmd_code;
  logic             cmd_ready;
  logic             halt_in_id;
  logic             id_ex_mem_read;
  logic [4:0]       id_ex_rt;
  logic [4:0]       if_id_rs;
  logic [4:0]       if_id_rt;
  logic             branch_taken;
  logic             pipe_en;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             pipe_clear;
  logic [2:0]       state;
  logic             done;
  logic [CNT_W-1:0] cycle_count;

  pipeline_sequencer #(.DRAIN_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_ready(cmd_ready), .halt_in_id(halt_in_id), .id_ex_mem_read(id_ex_mem_read),
    .id_ex_rt(id_ex_rt), .if_id_rs(if_id_rs), .if_id_rt(if_id_rt),
    .branch_taken(branch_taken), .pipe_en(pipe_en), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .id_ex_bubble(id_ex_bubble),
    .pipe_clear(pipe_clear), .state(state), .done(done), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  // Snapshot order: state, pipe_en, cmd_ready, pc_write, if_id_write, if_id_flush,
  // id_ex_bubble, pipe_clear, done, cycle_count.
  typedef logic [3+8+CNT_W-1:0] snap_t;
  typedef struct {
    string name;
    snap_t exp;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  localparam logic [1:0] RUN = 2'b00, STEP = 2'b01, PAUSE = 2'b10, CLEAR = 2'b11;

  task automatic check(input string name, input snap_t act, input snap_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got st/pe/rdy/pcw/ifw/fl/bub/clr/done/cnt=%b_%b_%b required %b_%b_%b",
               name, act[3+8+CNT_W-1 -: 3], act[8+CNT_W-1 -: 8], act[CNT_W-1:0],
               exp[3+8+CNT_W-1 -: 3], exp[8+CNT_W-1 -: 8], exp[CNT_W-1:0]);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      check(e.name, {state, pipe_en, cmd_ready, pc_write, if_id_write, if_id_flush,
                     id_ex_bubble, pipe_clear, done, cycle_count}, e.exp);
    end
  end

  task automatic drive(input logic cv, input logic [1:0] cc, input logic h, input logic mr,
                       input logic [4:0] ert, input logic [4:0] rs, input logic [4:0] rt,
                       input logic br);
    cmd_valid = cv; cmd_code = cc; halt_in_id = h; id_ex_mem_read = mr;
    id_ex_rt = ert; if_id_rs = rs; if_id_rt = rt; branch_taken = br;
  endtask

  task automatic quiet();
    drive(1'b0, RUN, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
  endtask

  // Queue the expected outputs for the current cycle, then advance past the next edge.
  task automatic expect_cyc(input string name, input logic [2:0] st, input logic pe,
                            input logic rdy, input logic pcw, input logic fl, input logic bub,
                            input logic clr, input logic dn, input logic [CNT_W-1:0] cnt);
    exp_t e;
    e.name = name;
    e.exp  = {st, pe, rdy, pcw, pcw, fl, bub, clr, dn, cnt};
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    drive(1'b1, RUN, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    @(posedge clk);
    #1;
    expect_cyc("reset_hold", 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    reset = 1'b0;
    quiet();
    expect_cyc("idle_after_reset", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0);

    // Run for ten cycles, pause on the last.
    drive(1'b1, RUN, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("run_cmd", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0);
    for (int k = 0; k < 10; k++) begin
      if (k == 9) drive(1'b1, PAUSE, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      else        quiet();
      expect_cyc($sformatf("run_%0d", k), 3'd1, 1, 1, 1, 0, 0, 0, 0, CNT_W'(k));
    end
    quiet();
    expect_cyc("paused_idle", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd10);

    // CLEAR from IDLE: one-cycle pipe_clear, counter zeroed.
    drive(1'b1, CLEAR, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("clear_cmd_idle", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd10);
    drive(1'b1, RUN, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("clear_pulse", 3'd0, 0, 1, 0, 0, 0, 1, 0, 4'd0);

    // Hazards during RUN.
    drive(1'b0, RUN, 1'b0, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    expect_cyc("stall_rs", 3'd1, 1, 1, 0, 0, 1, 0, 0, 4'd0);
    drive(1'b0, RUN, 1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("no_stall_r0", 3'd1, 1, 1, 1, 0, 0, 0, 0, 4'd1);
    drive(1'b0, RUN, 1'b0, 1'b1, 5'd5, 5'd3, 5'd5, 1'b0);
    expect_cyc("stall_rt", 3'd1, 1, 1, 0, 0, 1, 0, 0, 4'd2);
    drive(1'b0, RUN, 1'b0, 1'b0, 5'd5, 5'd5, 5'd5, 1'b1);
    expect_cyc("branch_flush", 3'd1, 1, 1, 1, 1, 0, 0, 0, 4'd3);
    drive(1'b0, RUN, 1'b0, 1'b1, 5'd7, 5'd7, 5'd1, 1'b1);
    expect_cyc("branch_stalled", 3'd1, 1, 1, 0, 0, 1, 0, 0, 4'd4);
    drive(1'b0, RUN, 1'b0, 1'b1, 5'd7, 5'd6, 5'd8, 1'b1);
    expect_cyc("branch_load_nodep", 3'd1, 1, 1, 1, 1, 0, 0, 0, 4'd5);

    // HALT blocked by a stall, then HALT with a simultaneous PAUSE.
    drive(1'b0, RUN, 1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b0);
    expect_cyc("halt_stalled", 3'd1, 1, 1, 0, 0, 1, 0, 0, 4'd6);
    drive(1'b1, PAUSE, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("halt_with_pause", 3'd1, 1, 1, 0, 0, 1, 0, 0, 4'd7);
    for (int d = 0; d < 4; d++) begin
      drive(1'b0, RUN, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1);
      expect_cyc($sformatf("drain_%0d", d), 3'd3, 1, 0, 0, 0, 1, 0, 0, CNT_W'(8 + d));
    end
    drive(1'b1, RUN, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("done_run_ignored", 3'd4, 0, 1, 0, 0, 0, 0, 1, 4'd12);
    drive(1'b1, CLEAR, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("done_still", 3'd4, 0, 1, 0, 0, 0, 0, 1, 4'd12);
    quiet();
    expect_cyc("done_clear_pulse", 3'd0, 0, 1, 0, 0, 0, 1, 0, 4'd0);
    expect_cyc("clear_pulse_ends", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0);

    // Three single steps; the second one stalls.
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, STEP, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      expect_cyc($sformatf("step_cmd_%0d", s), 3'd0, 0, 1, 0, 0, 0, 0, 0, CNT_W'(s));
      if (s == 1) begin
        drive(1'b1, STEP, 1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0);
        expect_cyc("step_stalled", 3'd2, 1, 0, 0, 0, 1, 0, 0, CNT_W'(s));
      end else begin
        drive(1'b1, STEP, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
        expect_cyc($sformatf("step_%0d", s), 3'd2, 1, 0, 1, 0, 0, 0, 0, CNT_W'(s));
      end
    end
    quiet();
    expect_cyc("steps_done", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd3);

    // HALT during STEP, then reset in the third DRAIN cycle.
    drive(1'b1, STEP, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("step_cmd_halt", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd3);
    drive(1'b0, RUN, 1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("step_halt", 3'd2, 1, 0, 0, 0, 1, 0, 0, 4'd3);
    quiet();
    expect_cyc("sdrain_0", 3'd3, 1, 0, 0, 0, 1, 0, 0, 4'd4);
    expect_cyc("sdrain_1", 3'd3, 1, 0, 0, 0, 1, 0, 0, 4'd5);
    reset = 1'b1;
    drive(1'b1, RUN, 1'b1, 1'b1, 5'd5, 5'd5, 5'd5, 1'b1);
    expect_cyc("reset_in_drain", 3'd3, 0, 0, 0, 0, 0, 0, 0, 4'd6);
    expect_cyc("reset_abort", 3'd0, 0, 0, 0, 0, 0, 0, 0, 4'd0);
    reset = 1'b0;
    quiet();
    expect_cyc("post_abort_idle", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0);

    // Counter saturation at all ones.
    drive(1'b1, RUN, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    expect_cyc("sat_run_cmd", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd0);
    for (int k = 0; k < 18; k++) begin
      if (k == 17) drive(1'b1, PAUSE, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
      else         quiet();
      expect_cyc($sformatf("sat_%0d", k), 3'd1, 1, 1, 1, 0, 0, 0, 0,
                 (k > 15) ? 4'd15 : CNT_W'(k));
    end
    quiet();
    expect_cyc("sat_idle", 3'd0, 0, 1, 0, 0, 0, 0, 0, 4'd15);

    for (int w = 0; w < 4 && exp_q.size() > 0; w++) @(negedge clk);
    if (exp_q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain_queue: got %0d pending required 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
